// File: rtl/dvd_operand_feeder.sv
// Operand feeder for the divider accelerator: buffers dividend/divisor pairs
// and replays each pair as two ready-gated StartData strobes.
module dvd_operand_feeder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         PushValid,
    input  logic [WIDTH-1:0]             PushDividend,
    input  logic [WIDTH-1:0]             PushDivisor,
    output logic                         PushReady,
    input  logic                         ReadyToAccept,
    input  logic                         OutBuffFull,
    output logic                         StartData,
    output logic [WIDTH-1:0]             Input_Data,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    output logic                         Busy,
    output logic [CNT_W-1:0]             PairsSent
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] SENT_ONE = CNT_W'(1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WAIT_A = 3'd1;
    localparam logic [2:0] SEND_A = 3'd2;
    localparam logic [2:0] GAP_A  = 3'd3;
    localparam logic [2:0] WAIT_B = 3'd4;
    localparam logic [2:0] SEND_B = 3'd5;
    localparam logic [2:0] GAP_B  = 3'd6;

    logic [WIDTH-1:0] r_mem_dvd [DEPTH];
    logic [WIDTH-1:0] r_mem_dvs [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_push_ready;
    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_divisor;
    logic             r_start;
    logic [WIDTH-1:0] r_data;
    logic             r_busy;
    logic [CNT_W-1:0] r_pairs;

    logic             w_push;
    logic             w_pop;
    logic [2:0]       w_state_nxt;
    logic [CW-1:0]    w_count_nxt;

    // A full FIFO refuses pushes even when a pop lands in the same cycle.
    assign w_push = PushValid && r_push_ready;
    assign w_pop  = (r_state == IDLE) && (r_count != {CW{1'b0}}) && !OutBuffFull;

    // Next-state logic for the pair replay sequence
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_pop) w_state_nxt = WAIT_A; else w_state_nxt = IDLE;
            WAIT_A:  if (ReadyToAccept) w_state_nxt = SEND_A; else w_state_nxt = WAIT_A;
            SEND_A:  w_state_nxt = GAP_A;
            GAP_A:   w_state_nxt = WAIT_B;
            WAIT_B:  if (ReadyToAccept) w_state_nxt = SEND_B; else w_state_nxt = WAIT_B;
            SEND_B:  w_state_nxt = GAP_B;
            GAP_B:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Queue occupancy update
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_ONE;
        end else begin
            w_count_nxt = r_count;
        end
    end

    // FIFO storage; contents need no reset since Count gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_dvd[r_wr_ptr] <= PushDividend;
            r_mem_dvs[r_wr_ptr] <= PushDivisor;
        end
    end

    // Control state, pointers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_wr_ptr     <= {PTR_W{1'b0}};
            r_rd_ptr     <= {PTR_W{1'b0}};
            r_count      <= {CW{1'b0}};
            r_push_ready <= 1'b1;
            r_divisor    <= {WIDTH{1'b0}};
            r_start      <= 1'b0;
            r_data       <= {WIDTH{1'b0}};
            r_busy       <= 1'b0;
            r_pairs      <= {CNT_W{1'b0}};
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_push_ready <= (w_count_nxt < FULL_CNT);
            r_start      <= (w_state_nxt == SEND_A) || (w_state_nxt == SEND_B);
            r_busy       <= (w_state_nxt != IDLE);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            // Dividend goes straight onto the bus; divisor waits until GAP_A ends.
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + PTR_ONE;
                r_data    <= r_mem_dvd[r_rd_ptr];
                r_divisor <= r_mem_dvs[r_rd_ptr];
            end else if (r_state == GAP_A) begin
                r_data <= r_divisor;
            end
            if (r_state == SEND_B) begin
                r_pairs <= r_pairs + SENT_ONE;
            end
        end
    end

    assign PushReady  = r_push_ready;
    assign StartData  = r_start;
    assign Input_Data = r_data;
    assign Count      = r_count;
    assign Busy       = r_busy;
    assign PairsSent  = r_pairs;

endmodule

// File: tb/tb_dvd_operand_feeder.sv
// Directed bench for dvd_operand_feeder: vector table plus hand-written
// sequences for backpressure, OutBuffFull, mid-pair reset and counter wrap.
module tb_dvd_operand_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       PushValid = 1'b0;
    logic [7:0] PushDividend = 8'd0;
    logic [7:0] PushDivisor = 8'd0;
    logic       PushReady;
    logic       ReadyToAccept = 1'b0;
    logic       OutBuffFull = 1'b0;
    logic       StartData;
    logic [7:0] Input_Data;
    logic [2:0] Count;
    logic       Busy;
    logic [7:0] PairsSent;

    dvd_operand_feeder #(.WIDTH(8), .DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .PushValid(PushValid), .PushDividend(PushDividend), .PushDivisor(PushDivisor),
        .PushReady(PushReady), .ReadyToAccept(ReadyToAccept), .OutBuffFull(OutBuffFull),
        .StartData(StartData), .Input_Data(Input_Data), .Count(Count),
        .Busy(Busy), .PairsSent(PairsSent)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } vec_t;

    vec_t       vecs [8];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         exp_pairs = 0;
    logic [7:0] obs [$];
    logic       rdy_at_edge = 1'b0;
    logic [7:0] prev_data = 8'd0;
    int         since_strobe = 100;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ready value seen by the DUT at each rising edge
    always @(posedge clk) rdy_at_edge <= ReadyToAccept;

    // Strobe monitor: ready-gated, data held since WAIT, spacing >= 3 cycles
    always @(negedge clk) begin
        if (StartData) begin
            chk("strobe_after_ready", int'(rdy_at_edge), 1);
            chk("data_stable_wait_send", int'(Input_Data), int'(prev_data));
            chk("strobe_spacing_ge3", int'(since_strobe >= 3), 1);
            obs.push_back(Input_Data);
            since_strobe = 1;
        end else begin
            since_strobe++;
        end
        prev_data = Input_Data;
    end

    task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
        bit ok = 1'b0;
        PushValid = 1'b1;
        PushDividend = a;
        PushDivisor = b;
        for (int c = 0; c < 200 && !ok; c++) begin
            if (PushReady) ok = 1'b1;
            tick();
        end
        PushValid = 1'b0;
        chk("push_accepted", int'(ok), 1);
    endtask

    task automatic wait_idle(input int bound, input bit rand_rdy);
        bit done = 1'b0;
        for (int c = 0; c < bound && !done; c++) begin
            if (!Busy && Count == 3'd0) begin
                done = 1'b1;
            end else begin
                if (rand_rdy) ReadyToAccept = 1'($urandom_range(0, 1));
                tick();
            end
        end
        chk("idle_within_bound", int'(done), 1);
    endtask

    task automatic check_obs(input int first, input int n);
        chk("strobe_count", obs.size(), 2 * n);
        for (int k = 0; k < n; k++) begin
            if (2 * k + 1 < obs.size()) begin
                chk("dividend_order", int'(obs[2*k]), int'(vecs[first+k].exp_a));
                chk("divisor_order", int'(obs[2*k+1]), int'(vecs[first+k].exp_b));
            end
        end
    endtask

    initial begin
        vecs[0] = '{dvd: 8'd99,  dvs: 8'd10, exp_a: 8'd99,  exp_b: 8'd10};
        vecs[1] = '{dvd: 8'd11,  dvs: 8'd22, exp_a: 8'd11,  exp_b: 8'd22};
        vecs[2] = '{dvd: 8'd33,  dvs: 8'd44, exp_a: 8'd33,  exp_b: 8'd44};
        vecs[3] = '{dvd: 8'd55,  dvs: 8'd66, exp_a: 8'd55,  exp_b: 8'd66};
        vecs[4] = '{dvd: 8'd77,  dvs: 8'd88, exp_a: 8'd77,  exp_b: 8'd88};
        vecs[5] = '{dvd: 8'd255, dvs: 8'd0,  exp_a: 8'd255, exp_b: 8'd0};
        vecs[6] = '{dvd: 8'd0,   dvs: 8'd99, exp_a: 8'd0,   exp_b: 8'd99};
        vecs[7] = '{dvd: 8'd200, dvs: 8'd7,  exp_a: 8'd200, exp_b: 8'd7};

        // Reset state
        tick(); tick();
        chk("rst_StartData", int'(StartData), 0);
        chk("rst_Input_Data", int'(Input_Data), 0);
        chk("rst_Busy", int'(Busy), 0);
        chk("rst_PairsSent", int'(PairsSent), 0);
        chk("rst_Count", int'(Count), 0);
        chk("rst_PushReady", int'(PushReady), 1);
        rst = 1'b0;

        // Single pair, ready held high
        ReadyToAccept = 1'b1;
        push_pair(vecs[0].dvd, vecs[0].dvs);
        wait_idle(50, 1'b0);
        exp_pairs += 1;
        check_obs(0, 1);
        chk("t1_PairsSent", int'(PairsSent), exp_pairs);
        chk("t1_Count", int'(Count), 0);

        // Fill the FIFO under backpressure, then drain in push order
        obs.delete();
        ReadyToAccept = 1'b0;
        for (int i = 0; i < 5; i++) push_pair(vecs[i].dvd, vecs[i].dvs);
        chk("t2_Count_full", int'(Count), 4);
        chk("t2_PushReady_full", int'(PushReady), 0);
        PushValid = 1'b1;
        PushDividend = vecs[5].dvd;
        PushDivisor = vecs[5].dvs;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_push_refused", int'(Count), 4);
        end
        ReadyToAccept = 1'b1;
        push_pair(vecs[5].dvd, vecs[5].dvs);
        wait_idle(100, 1'b0);
        exp_pairs += 6;
        check_obs(0, 6);
        chk("t2_PairsSent", int'(PairsSent), exp_pairs);

        // Random ready toggling
        obs.delete();
        ReadyToAccept = 1'b0;
        push_pair(vecs[6].dvd, vecs[6].dvs);
        push_pair(vecs[7].dvd, vecs[7].dvs);
        wait_idle(300, 1'b1);
        exp_pairs += 2;
        check_obs(6, 2);
        chk("t3_PairsSent", int'(PairsSent), exp_pairs);

        // OutBuffFull holds off launch but never aborts a popped pair
        obs.delete();
        OutBuffFull = 1'b1;
        ReadyToAccept = 1'b1;
        push_pair(8'd30, 8'd3);
        push_pair(8'd40, 8'd4);
        repeat (4) tick();
        chk("t4_obf_Busy", int'(Busy), 0);
        chk("t4_obf_Count", int'(Count), 2);
        chk("t4_obf_no_strobe", obs.size(), 0);
        ReadyToAccept = 1'b0;
        OutBuffFull = 1'b0;
        tick(); tick();
        chk("t4_popped_Busy", int'(Busy), 1);
        chk("t4_popped_Count", int'(Count), 1);
        ReadyToAccept = 1'b1;
        tick();
        ReadyToAccept = 1'b0;
        tick(); tick(); tick();
        OutBuffFull = 1'b1;
        ReadyToAccept = 1'b1;
        begin
            bit done = 1'b0;
            for (int c = 0; c < 20 && !done; c++) begin
                if (int'(PairsSent) == exp_pairs + 1) done = 1'b1;
                else tick();
            end
            chk("t4_divisor_despite_obf", int'(done), 1);
        end
        exp_pairs += 1;
        repeat (6) tick();
        chk("t4_hold_Busy", int'(Busy), 0);
        chk("t4_hold_Count", int'(Count), 1);
        chk("t4_hold_strobes", obs.size(), 2);
        OutBuffFull = 1'b0;
        wait_idle(50, 1'b0);
        exp_pairs += 1;
        chk("t4_strobes", obs.size(), 4);
        if (obs.size() == 4) begin
            chk("t4_a0", int'(obs[0]), 30);
            chk("t4_b0", int'(obs[1]), 3);
            chk("t4_a1", int'(obs[2]), 40);
            chk("t4_b1", int'(obs[3]), 4);
        end
        chk("t4_PairsSent", int'(PairsSent), exp_pairs);

        // Reset during WAIT_B abandons the pair and empties the FIFO
        obs.delete();
        ReadyToAccept = 1'b0;
        push_pair(8'd50, 8'd5);
        push_pair(8'd1, 8'd2);
        push_pair(8'd3, 8'd4);
        ReadyToAccept = 1'b1;
        tick();
        ReadyToAccept = 1'b0;
        tick(); tick();
        chk("t5_Busy_waitb", int'(Busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_pairs = 0;
        chk("t5_Count", int'(Count), 0);
        chk("t5_PairsSent", int'(PairsSent), 0);
        chk("t5_PushReady", int'(PushReady), 1);
        chk("t5_Busy", int'(Busy), 0);
        chk("t5_Input_Data", int'(Input_Data), 0);
        ReadyToAccept = 1'b1;
        repeat (10) tick();
        chk("t5_only_dividend", obs.size(), 1);

        // 256 pairs: counter wrap and pointer wrap without loss or duplication
        obs.delete();
        for (int i = 0; i < 256; i++) push_pair(8'(i), 8'd1);
        wait_idle(100, 1'b0);
        chk("t6_PairsSent_wrap", int'(PairsSent), 0);
        chk("t6_strobes", obs.size(), 512);
        if (obs.size() == 512) begin
            for (int i = 0; i < 256; i++) begin
                chk("t6_dividend", int'(obs[2*i]), i);
                chk("t6_divisor", int'(obs[2*i+1]), 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
